// File: rtl/clock_set_controller.sv
// Tick generator and set-time sequencer for the 24 h BCD binary_clock.
// Optional set-mode inactivity timeout: define CLOCK_SET_TIMEOUT_EN.
module clock_set_controller #(
  parameter int unsigned TICK_DIV      = 12000000,
  parameter int unsigned BLINK_DIV     = 3000000,
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [13:0] count_in,
  output logic        ce,
  output logic        load,
  output logic [13:0] load_value,
  output logic [1:0]  set_field,
  output logic        blink
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    LOAD
  } state_t;

  state_t state, state_n;

  logic          mode_q, inc_q, armed;
  logic          mode_e, inc_e;
  logic [PW-1:0] pre;
  logic          pre_wrap;
  logic [13:0]   shadow, shadow_n;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          in_set, in_set_n;
  logic          to_fire;

  // Field value as binary, +1 with wrap past lim, back to BCD.
  function automatic logic [7:0] bump(
    input logic [7:0] f,
    input logic [7:0] lim
  );
    logic [7:0] v;
    logic [3:0] t;
    v = 8'(f[7:4]) * 8'd10 + 8'(f[3:0]);
    v = (v >= lim) ? 8'd0 : v + 8'd1;
    t = 4'd0;
    for (int i = 1; i < 6; i++)
      if (v >= 8'(i * 10)) t = 4'(i);
    bump = {t, 4'(v - 8'(t) * 8'd10)};
  endfunction

  // armed masks a button held high across reset release.
  assign mode_e   = armed & btn_mode & ~mode_q;
  assign inc_e    = armed & btn_inc & ~inc_q;
  assign pre_wrap = (pre == PW'(TICK_DIV - 1));
  assign in_set   = (state == SET_HOUR) || (state == SET_MIN);
  assign in_set_n = (state_n == SET_HOUR) || (state_n == SET_MIN);

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    unique case (state)
      RUN: begin
        if (mode_e) begin
          state_n  = SET_HOUR;
          shadow_n = count_in;
        end
      end
      SET_HOUR: begin
        if (mode_e)
          state_n = SET_MIN;
        else if (inc_e)
          shadow_n[13:8] = 6'(bump({2'b00, shadow[13:8]}, 8'd23));
      end
      SET_MIN: begin
        if (mode_e)
          state_n = LOAD;
        else if (inc_e)
          shadow_n[7:0] = bump(shadow[7:0], 8'd59);
      end
      LOAD: state_n = RUN;
      default: state_n = RUN;
    endcase
    if (in_set && !mode_e && !inc_e && to_fire)
      state_n = RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      mode_q     <= 1'b0;
      inc_q      <= 1'b0;
      armed      <= 1'b0;
      pre        <= '0;
      ce         <= 1'b0;
      load_value <= '0;
      shadow     <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      armed  <= 1'b1;
      shadow <= shadow_n;
      ce     <= (state == RUN) && !mode_e && pre_wrap;
      if ((state == RUN || state == LOAD) && !in_set_n && !pre_wrap)
        pre <= pre + 1'b1;
      else
        pre <= '0;
      if (state_n == LOAD)
        load_value <= shadow;
      if (in_set_n && state_n != state) begin
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [PW-1:0] tcnt;
  logic [TW-1:0] toc;

  assign to_fire = (tcnt == PW'(TICK_DIV - 1)) &&
                   (toc == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (!reset || !in_set || mode_e || inc_e) begin
      tcnt <= '0;
      toc  <= '0;
    end else if (tcnt == PW'(TICK_DIV - 1)) begin
      tcnt <= '0;
      toc  <= toc + 1'b1;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  assign load      = reset & (state == LOAD);
  assign set_field = {2{reset}} & {state == SET_MIN, state == SET_HOUR};
  assign blink     = reset & in_set & phase;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed + randomized bench for clock_set_controller.
// Shadow edits are predicted with plain decimal arithmetic.
module tb_clock_set_controller;

  localparam int TD = 4;
  localparam int BD = 3;
  localparam int TT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic [13:0] count_in = '0;
  logic        ce, load, blink;
  logic [13:0] load_value;
  logic [1:0]  set_field;

  int total = 0;
  int passed = 0;
  int loads = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  clock_set_controller #(
    .TICK_DIV     (TD),
    .BLINK_DIV    (BD),
    .TIMEOUT_TICKS(TT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .count_in  (count_in),
    .ce        (ce),
    .load      (load),
    .load_value(load_value),
    .set_field (set_field),
    .blink     (blink)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick();
  endtask

  // Decimal model of one increment on a BCD field.
  function automatic logic [7:0] step_field(input logic [7:0] f,
                                            input int lim);
    int v;
    v = int'(f[7:4]) * 10 + int'(f[3:0]);
    v = (v >= lim) ? 0 : v + 1;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (load === 1'b1) loads++;
      chk("ce_load_excl", 32'(ce & load), 0);
      chk("ce_in_set", 32'(ce & (set_field != 2'b00)), 0);
    end
  end

  task automatic run_set(input logic [13:0] cin,
                         input int nh,
                         input int nm,
                         input string tag);
    logic [13:0] exp;
    logic [7:0]  f;
    int          l0;
    exp = cin;
    l0 = loads;
    count_in = cin;
    press(1'b1, 1'b0);
    chk({tag, "_sf_hour"}, 32'(set_field), 1);
    for (int k = 0; k < nh; k++) begin
      press(1'b0, 1'b1);
      f = step_field({2'b00, exp[13:8]}, 23);
      exp[13:8] = f[5:0];
    end
    press(1'b1, 1'b0);
    chk({tag, "_sf_min"}, 32'(set_field), 2);
    for (int k = 0; k < nm; k++) begin
      press(1'b0, 1'b1);
      exp[7:0] = step_field(exp[7:0], 59);
    end
    btn_mode = 1'b1;
    tick();
    chk({tag, "_load"}, 32'(load), 1);
    chk({tag, "_load_value"}, 32'(load_value), 32'(exp));
    btn_mode = 1'b0;
    for (int k = 1; k < TD; k++) begin
      tick();
      chk({tag, "_ce_gap"}, 32'(ce), 0);
    end
    tick();
    chk({tag, "_ce_first"}, 32'(ce), 1);
    chk({tag, "_sf_run"}, 32'(set_field), 0);
    chk({tag, "_one_load"}, 32'(loads - l0), 1);
  endtask

  initial begin
    logic [13:0] cin;
    int          l0;

    btn_mode = 1'b1;
    repeat (3) tick();
    chk("rst_ce", 32'(ce), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_load_value", 32'(load_value), 0);
    chk("rst_set_field", 32'(set_field), 0);
    chk("rst_blink", 32'(blink), 0);
    mon_en = 1'b1;

    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("run_ce", 32'(ce), 32'((k % TD) == 0));
      chk("run_held_btn", 32'(set_field), 0);
      chk("run_load", 32'(load), 0);
    end
    btn_mode = 1'b0;
    tick();

    run_set({2'd2, 4'd3, 4'd5, 4'd9}, 1, 1, "t2359");
    chk("t2359_zero", 32'(load_value), 0);
    run_set({2'd0, 4'd9, 4'd0, 4'd9}, 1, 1, "t0909");
    chk("t0909_ten", 32'(load_value), 32'({2'd1, 4'd0, 4'd1, 4'd0}));
    run_set({2'd2, 4'd7, 4'd7, 4'd3}, 1, 1, "t_oor");
    run_set({2'd1, 4'd5, 4'd4, 4'd2}, 0, 0, "t_noinc");
    for (int r = 0; r < 6; r++) begin
      cin = 14'($urandom);
      run_set(cin, int'($urandom_range(0, 26)),
              int'($urandom_range(0, 62)), "t_rand");
    end

    cin = {2'd1, 4'd2, 4'd3, 4'd4};
    count_in = cin;
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    for (int k = 0; k < 2 * BD; k++) begin
      chk("blink_phase", 32'(blink), 32'((k / BD) % 2));
      tick();
    end
    press(1'b1, 1'b1);
    chk("simul_sf", 32'(set_field), 2);
    btn_mode = 1'b1;
    tick();
    chk("simul_load", 32'(load), 1);
    chk("simul_value", 32'(load_value), 32'(cin));
    btn_mode = 1'b0;
    tick();
    chk("run_blink", 32'(blink), 0);

    l0 = loads;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("mid_sf_min", 32'(set_field), 2);
    reset = 1'b0;
    tick();
    chk("mid_rst_sf", 32'(set_field), 0);
    chk("mid_rst_load", 32'(load), 0);
    reset = 1'b1;
    repeat (8) tick();
    chk("mid_no_load", 32'(loads - l0), 0);
    chk("mid_run", 32'(set_field), 0);

    l0 = loads;
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    chk("idle_enter", 32'(set_field), 1);
`ifdef CLOCK_SET_TIMEOUT_EN
    repeat (TD * TT - 1) tick();
    chk("to_before", 32'(set_field), 1);
    tick();
    chk("to_abort", 32'(set_field), 0);
    chk("to_no_load", 32'(loads - l0), 0);
`else
    repeat (100) tick();
    chk("idle_persist", 32'(set_field), 1);
    chk("idle_no_load", 32'(loads - l0), 0);
`endif

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
